mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/arb_grant.sv | 21 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding, master IDs and round-robin pointer reset value
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP} state_e;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic RR_PTR_RST = ID_DATA;
  localparam int RESP_W = 32;
endpackage

// File: rtl/arb_grant.sv
// arb_grant: picks the master to grant; round-robin when MEM_ARBITER_RR_EN is defined, else fixed m1 priority
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic gnt_o
);
  logic ptr_q, ptr_d;
  assign gnt_o = (req0_i && req1_i) ? ptr_q : (req1_i ? ID_DATA : ID_INST);
`ifdef MEM_ARBITER_RR_EN
  assign ptr_d = take_i ? ~gnt_o : ptr_q;
`else
  // pointer pinned to m1, which makes the tie-break a fixed priority
  assign ptr_d = take_i ? ID_DATA : ptr_q;
`endif
  always_ff @(posedge clk) ptr_q <= rst ? RR_PTR_RST : ptr_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache (m0) and dcache (m1) reads/writes onto one memory port
// MEM_ARBITER_RR_EN selects round-robin arbitration instead of fixed m1 priority
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_readAddr_addr,
  input  logic                m0_readAddr_valid,
  output logic                m0_readAddr_ready,
  output logic [DATA_W-1:0]   m0_readData_data,
  output logic                m0_readData_valid,
  input  logic                m0_readData_ready,
  input  logic [ADDR_W-1:0]   m0_writeAddr_addr,
  input  logic                m0_writeAddr_valid,
  output logic                m0_writeAddr_ready,
  input  logic [DATA_W-1:0]   m0_writeData_data,
  input  logic [DATA_W/8-1:0] m0_writeData_strb,
  input  logic                m0_writeData_valid,
  output logic                m0_writeData_ready,
  output logic [RESP_W-1:0]   m0_writeResp_msg,
  output logic                m0_writeResp_valid,
  input  logic                m0_writeResp_ready,
  input  logic [ADDR_W-1:0]   m1_readAddr_addr,
  input  logic                m1_readAddr_valid,
  output logic                m1_readAddr_ready,
  output logic [DATA_W-1:0]   m1_readData_data,
  output logic                m1_readData_valid,
  input  logic                m1_readData_ready,
  input  logic [ADDR_W-1:0]   m1_writeAddr_addr,
  input  logic                m1_writeAddr_valid,
  output logic                m1_writeAddr_ready,
  input  logic [DATA_W-1:0]   m1_writeData_data,
  input  logic [DATA_W/8-1:0] m1_writeData_strb,
  input  logic                m1_writeData_valid,
  output logic                m1_writeData_ready,
  output logic [RESP_W-1:0]   m1_writeResp_msg,
  output logic                m1_writeResp_valid,
  input  logic                m1_writeResp_ready,
  output logic [ADDR_W-1:0]   s_readAddr_addr,
  output logic                s_readAddr_valid,
  input  logic                s_readAddr_ready,
  input  logic [DATA_W-1:0]   s_readData_data,
  input  logic                s_readData_valid,
  output logic                s_readData_ready,
  output logic [ADDR_W-1:0]   s_writeAddr_addr,
  output logic                s_writeAddr_valid,
  input  logic                s_writeAddr_ready,
  output logic [DATA_W-1:0]   s_writeData_data,
  output logic [DATA_W/8-1:0] s_writeData_strb,
  output logic                s_writeData_valid,
  input  logic                s_writeData_ready,
  input  logic [RESP_W-1:0]   s_writeResp_msg,
  input  logic                s_writeResp_valid,
  output logic                s_writeResp_ready,
  output logic                busy
);
  state_e state_q, state_d;
  logic gnt_q, gnt_d, wr_q, wr_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic req0, req1, pick, take;
  logic in_ra, in_rd, in_wx, in_wr;
  logic ra_hs, rd_hs, aw_hs, w_hs, wr_hs;
  assign req0 = m0_readAddr_valid | m0_writeAddr_valid;
  assign req1 = m1_readAddr_valid | m1_writeAddr_valid;
  assign take = (state_q == IDLE) && (req0 || req1);
  arb_grant u_grant (
    .clk    (clk),
    .rst    (rst),
    .req0_i (req0),
    .req1_i (req1),
    .take_i (take),
    .gnt_o  (pick)
  );
  assign in_ra = state_q == RD_ADDR;
  assign in_rd = state_q == RD_DATA;
  assign in_wx = state_q == WR_XFER;
  assign in_wr = state_q == WR_RESP;
  assign busy  = state_q != IDLE;
  assign s_readAddr_addr    = gnt_q ? m1_readAddr_addr : m0_readAddr_addr;
  assign s_readAddr_valid   = in_ra && (gnt_q ? m1_readAddr_valid : m0_readAddr_valid);
  assign m0_readAddr_ready  = in_ra && !gnt_q && s_readAddr_ready;
  assign m1_readAddr_ready  = in_ra && gnt_q && s_readAddr_ready;
  assign m0_readData_data   = s_readData_data;
  assign m1_readData_data   = s_readData_data;
  assign m0_readData_valid  = in_rd && !gnt_q && s_readData_valid;
  assign m1_readData_valid  = in_rd && gnt_q && s_readData_valid;
  assign s_readData_ready   = in_rd && (gnt_q ? m1_readData_ready : m0_readData_ready);
  assign s_writeAddr_addr   = gnt_q ? m1_writeAddr_addr : m0_writeAddr_addr;
  assign s_writeAddr_valid  = in_wx && !aw_done_q && (gnt_q ? m1_writeAddr_valid : m0_writeAddr_valid);
  assign m0_writeAddr_ready = in_wx && !aw_done_q && !gnt_q && s_writeAddr_ready;
  assign m1_writeAddr_ready = in_wx && !aw_done_q && gnt_q && s_writeAddr_ready;
  assign s_writeData_data   = gnt_q ? m1_writeData_data : m0_writeData_data;
  assign s_writeData_strb   = gnt_q ? m1_writeData_strb : m0_writeData_strb;
  assign s_writeData_valid  = in_wx && !w_done_q && (gnt_q ? m1_writeData_valid : m0_writeData_valid);
  assign m0_writeData_ready = in_wx && !w_done_q && !gnt_q && s_writeData_ready;
  assign m1_writeData_ready = in_wx && !w_done_q && gnt_q && s_writeData_ready;
  assign m0_writeResp_msg   = s_writeResp_msg;
  assign m1_writeResp_msg   = s_writeResp_msg;
  assign m0_writeResp_valid = in_wr && !gnt_q && s_writeResp_valid;
  assign m1_writeResp_valid = in_wr && gnt_q && s_writeResp_valid;
  assign s_writeResp_ready  = in_wr && (gnt_q ? m1_writeResp_ready : m0_writeResp_ready);
  assign ra_hs = s_readAddr_valid && s_readAddr_ready;
  assign rd_hs = s_readData_valid && s_readData_ready;
  assign aw_hs = s_writeAddr_valid && s_writeAddr_ready;
  assign w_hs  = s_writeData_valid && s_writeData_ready;
  assign wr_hs = s_writeResp_valid && s_writeResp_ready;
  always_comb begin
    gnt_d     = take ? pick : gnt_q;
    wr_d      = take ? (pick ? m1_writeAddr_valid : m0_writeAddr_valid) : wr_q;
    aw_done_d = wr_hs ? 1'b0 : (aw_done_q || aw_hs);
    w_done_d  = wr_hs ? 1'b0 : (w_done_q || w_hs);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = take ? (wr_d ? WR_XFER : RD_ADDR) : IDLE;
      RD_ADDR: state_d = ra_hs ? RD_DATA : RD_ADDR;
      RD_DATA: state_d = rd_hs ? IDLE : RD_DATA;
      WR_XFER: state_d = (aw_done_d && w_done_d) ? WR_RESP : WR_XFER;
      WR_RESP: state_d = wr_hs ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= ID_INST;
      wr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter reads, writes, arbitration order and reset
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
`ifdef MEM_ARBITER_RR_EN
  localparam logic [6:0] ORDER = 7'b1010101;
`else
  localparam logic [6:0] ORDER = 7'b0111111;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_readAddr_addr, m1_readAddr_addr, m0_writeAddr_addr, m1_writeAddr_addr;
  logic m0_readAddr_valid, m0_readAddr_ready, m1_readAddr_valid, m1_readAddr_ready;
  logic [DW-1:0] m0_readData_data, m1_readData_data, m0_writeData_data, m1_writeData_data;
  logic m0_readData_valid, m0_readData_ready, m1_readData_valid, m1_readData_ready;
  logic m0_writeAddr_valid, m0_writeAddr_ready, m1_writeAddr_valid, m1_writeAddr_ready;
  logic [DW/8-1:0] m0_writeData_strb, m1_writeData_strb, s_writeData_strb;
  logic m0_writeData_valid, m0_writeData_ready, m1_writeData_valid, m1_writeData_ready;
  logic [31:0] m0_writeResp_msg, m1_writeResp_msg, s_writeResp_msg;
  logic m0_writeResp_valid, m0_writeResp_ready, m1_writeResp_valid, m1_writeResp_ready;
  logic [AW-1:0] s_readAddr_addr, s_writeAddr_addr;
  logic s_readAddr_valid, s_readAddr_ready;
  logic [DW-1:0] s_readData_data, s_writeData_data;
  logic s_readData_valid, s_readData_ready;
  logic s_writeAddr_valid, s_writeAddr_ready;
  logic s_writeData_valid, s_writeData_ready;
  logic s_writeResp_valid, s_writeResp_ready;
  logic busy;
  logic [4:0] mv0, mv1, sv;
  int n_vec = 0;
  int n_err = 0;

  assign mv0 = {m0_readAddr_ready, m0_readData_valid, m0_writeAddr_ready, m0_writeData_ready, m0_writeResp_valid};
  assign mv1 = {m1_readAddr_ready, m1_readData_valid, m1_writeAddr_ready, m1_writeData_ready, m1_writeResp_valid};
  assign sv  = {s_readAddr_valid, s_readData_ready, s_writeAddr_valid, s_writeData_valid, s_writeResp_ready};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_readAddr_addr(m0_readAddr_addr), .m0_readAddr_valid(m0_readAddr_valid), .m0_readAddr_ready(m0_readAddr_ready),
    .m0_readData_data(m0_readData_data), .m0_readData_valid(m0_readData_valid), .m0_readData_ready(m0_readData_ready),
    .m0_writeAddr_addr(m0_writeAddr_addr), .m0_writeAddr_valid(m0_writeAddr_valid), .m0_writeAddr_ready(m0_writeAddr_ready),
    .m0_writeData_data(m0_writeData_data), .m0_writeData_strb(m0_writeData_strb),
    .m0_writeData_valid(m0_writeData_valid), .m0_writeData_ready(m0_writeData_ready),
    .m0_writeResp_msg(m0_writeResp_msg), .m0_writeResp_valid(m0_writeResp_valid), .m0_writeResp_ready(m0_writeResp_ready),
    .m1_readAddr_addr(m1_readAddr_addr), .m1_readAddr_valid(m1_readAddr_valid), .m1_readAddr_ready(m1_readAddr_ready),
    .m1_readData_data(m1_readData_data), .m1_readData_valid(m1_readData_valid), .m1_readData_ready(m1_readData_ready),
    .m1_writeAddr_addr(m1_writeAddr_addr), .m1_writeAddr_valid(m1_writeAddr_valid), .m1_writeAddr_ready(m1_writeAddr_ready),
    .m1_writeData_data(m1_writeData_data), .m1_writeData_strb(m1_writeData_strb),
    .m1_writeData_valid(m1_writeData_valid), .m1_writeData_ready(m1_writeData_ready),
    .m1_writeResp_msg(m1_writeResp_msg), .m1_writeResp_valid(m1_writeResp_valid), .m1_writeResp_ready(m1_writeResp_ready),
    .s_readAddr_addr(s_readAddr_addr), .s_readAddr_valid(s_readAddr_valid), .s_readAddr_ready(s_readAddr_ready),
    .s_readData_data(s_readData_data), .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
    .s_writeAddr_addr(s_writeAddr_addr), .s_writeAddr_valid(s_writeAddr_valid), .s_writeAddr_ready(s_writeAddr_ready),
    .s_writeData_data(s_writeData_data), .s_writeData_strb(s_writeData_strb),
    .s_writeData_valid(s_writeData_valid), .s_writeData_ready(s_writeData_ready),
    .s_writeResp_msg(s_writeResp_msg), .s_writeResp_valid(s_writeResp_valid), .s_writeResp_ready(s_writeResp_ready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // entered at the negedge of the RD_ADDR cycle; returns at the negedge after the transaction, DUT idle
  task automatic serve_read(input string tag, input logic id, input logic [31:0] addr, input logic [127:0] data, input int lat);
    int bc;
    bc = 0;
    s_readAddr_ready = 1'b1;
    #1;
    check({tag, "_ra_valid"}, 128'(s_readAddr_valid), 128'd1);
    check({tag, "_ra_addr"}, 128'(s_readAddr_addr), 128'(addr));
    check({tag, "_ra_ready"}, 128'({m1_readAddr_ready, m0_readAddr_ready}), id ? 128'd2 : 128'd1);
    check({tag, "_other_quiet"}, 128'(id ? mv0 : mv1), 128'd0);
    bc += int'(busy);
    tick;
    s_readAddr_ready = 1'b0;
    if (id) m1_readAddr_valid = 1'b0;
    else m0_readAddr_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      check({tag, "_rd_wait"}, 128'({m1_readData_valid, m0_readData_valid, s_readAddr_valid}), 128'd0);
      bc += int'(busy);
      tick;
    end
    s_readData_valid = 1'b1;
    s_readData_data = data;
    #1;
    check({tag, "_rd_valid"}, 128'({m1_readData_valid, m0_readData_valid}), id ? 128'd2 : 128'd1);
    check({tag, "_rd_data"}, id ? m1_readData_data : m0_readData_data, data);
    check({tag, "_other_quiet_rd"}, 128'(id ? mv0 : mv1), 128'd0);
    bc += int'(busy);
    tick;
    s_readData_valid = 1'b0;
    #1;
    check({tag, "_busy_end"}, 128'(busy), 128'd0);
    check({tag, "_busy_cycles"}, 128'(bc), 128'(lat + 2));
  endtask

  initial begin
    rst = 1'b1;
    {m0_readAddr_addr, m1_readAddr_addr, m0_writeAddr_addr, m1_writeAddr_addr} = '0;
    {m0_readAddr_valid, m1_readAddr_valid, m0_writeAddr_valid, m1_writeAddr_valid} = '0;
    {m0_writeData_data, m1_writeData_data, m0_writeData_strb, m1_writeData_strb} = '0;
    {m0_writeData_valid, m1_writeData_valid} = '0;
    {m0_readData_ready, m1_readData_ready, m0_writeResp_ready, m1_writeResp_ready} = 4'b1111;
    {s_readAddr_ready, s_readData_valid, s_writeAddr_ready, s_writeData_ready, s_writeResp_valid} = '0;
    s_readData_data = '0;
    s_writeResp_msg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_handshakes", 128'({mv0, mv1, sv}), 128'd0);

    // single m0 read, data returned two cycles into RD_DATA
    m0_readAddr_addr = 32'h100;
    m0_readAddr_valid = 1'b1;
    #1;
    check("idle_no_ready", 128'({mv0, mv1, sv}), 128'd0);
    tick;
    serve_read("m0_read", 1'b0, 32'h100, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 2);

    // simultaneous reads: m1 wins, m0 follows
    m0_readAddr_addr = 32'h300;
    m1_readAddr_addr = 32'h400;
    m0_readAddr_valid = 1'b1;
    m1_readAddr_valid = 1'b1;
    tick;
    serve_read("tie_first", 1'b1, 32'h400, 128'hD1, 1);
    tick;
    serve_read("tie_second", 1'b0, 32'h300, 128'hD0, 1);

    // sustained contention: the served master re-requests for the first five grants
    m0_readAddr_valid = 1'b1;
    m1_readAddr_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick;
      serve_read($sformatf("order%0d", k), ORDER[k], ORDER[k] ? 32'h400 : 32'h300, 128'hC0DE_0000 + 128'(k), 0);
      if (k < 5) begin
        if (ORDER[k]) m1_readAddr_valid = 1'b1;
        else m0_readAddr_valid = 1'b1;
      end
    end

    // m1 write; data channel accepted three cycles after the address channel
    m1_writeAddr_addr = 32'h200;
    m1_writeAddr_valid = 1'b1;
    m1_writeData_data = 128'hFEED_FACE_CAFE_BEEF_0123_4567_89AB_CDEF;
    m1_writeData_strb = 16'hFFFF;
    m1_writeData_valid = 1'b1;
    tick;
    s_writeAddr_ready = 1'b1;
    #1;
    check("wr_aw_valid", 128'({s_writeAddr_valid, s_writeData_valid, s_readAddr_valid}), 128'd6);
    check("wr_aw_addr", 128'(s_writeAddr_addr), 128'h200);
    check("wr_strb", 128'(s_writeData_strb), 128'hFFFF);
    check("wr_data", s_writeData_data, 128'hFEED_FACE_CAFE_BEEF_0123_4567_89AB_CDEF);
    check("wr_m1_readys", 128'({m1_writeAddr_ready, m1_writeData_ready}), 128'd2);
    check("wr_m0_quiet", 128'(mv0), 128'd0);
    tick;
    s_writeAddr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wr_aw_done", 128'({s_writeAddr_valid, s_writeData_valid, m1_writeAddr_ready, busy}), 128'b0101);
      tick;
    end
    s_writeData_ready = 1'b1;
    #1;
    check("wr_w_hs", 128'({s_writeAddr_valid, s_writeData_valid, m1_writeData_ready}), 128'b011);
    tick;
    s_writeData_ready = 1'b0;
    m1_writeAddr_valid = 1'b0;
    m1_writeData_valid = 1'b0;
    s_writeResp_valid = 1'b1;
    s_writeResp_msg = 32'hA5A5_0001;
    #1;
    check("wr_resp", 128'({m1_writeResp_valid, s_writeResp_ready, s_writeData_valid, s_writeAddr_valid}), 128'b1100);
    check("wr_resp_msg", 128'(m1_writeResp_msg), 128'hA5A5_0001);
    tick;
    s_writeResp_valid = 1'b0;
    #1;
    check("wr_idle", 128'({busy, mv0, mv1, sv}), 128'd0);

    // m1 write and read together: write goes first
    m1_readAddr_addr = 32'h500;
    m1_readAddr_valid = 1'b1;
    m1_writeAddr_addr = 32'h600;
    m1_writeAddr_valid = 1'b1;
    m1_writeData_valid = 1'b1;
    s_writeAddr_ready = 1'b1;
    s_writeData_ready = 1'b1;
    tick;
    #1;
    check("wfirst_xfer", 128'({s_readAddr_valid, s_writeAddr_valid, s_writeData_valid}), 128'b011);
    check("wfirst_addr", 128'(s_writeAddr_addr), 128'h600);
    tick;
    s_writeAddr_ready = 1'b0;
    s_writeData_ready = 1'b0;
    m1_writeAddr_valid = 1'b0;
    m1_writeData_valid = 1'b0;
    s_writeResp_valid = 1'b1;
    s_writeResp_msg = 32'h0000_0002;
    #1;
    check("wfirst_resp", 128'({s_readAddr_valid, m1_writeResp_valid}), 128'b01);
    tick;
    s_writeResp_valid = 1'b0;
    #1;
    check("wfirst_idle", 128'({busy, s_readAddr_valid}), 128'd0);
    tick;
    serve_read("wfirst_read", 1'b1, 32'h500, 128'hBEEF, 1);

    // reset in the middle of RD_DATA abandons the read
    m0_readAddr_addr = 32'h700;
    m0_readAddr_valid = 1'b1;
    tick;
    s_readAddr_ready = 1'b1;
    tick;
    s_readAddr_ready = 1'b0;
    m0_readAddr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_pre_busy", 128'(busy), 128'd1);
    tick;
    rst = 1'b0;
    s_readData_valid = 1'b1;
    s_readData_data = 128'hDEAD;
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_handshakes", 128'({mv0, mv1, sv}), 128'd0);
    s_readData_valid = 1'b0;
    m0_readAddr_addr = 32'h800;
    m0_readAddr_valid = 1'b1;
    tick;
    serve_read("post_rst", 1'b0, 32'h800, 128'h5555_AAAA, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
